// File: rtl/logic_gate_bist.sv
// logic_gate_bist: WIDTH-input op-selectable gate with a registered output, plus a
// BIST sequencer that sweeps all 2^WIDTH vectors against a golden model.
// Ports: clk/rst_n; op, in_valid, in_data -> out_valid, out_y (1-cycle latency);
//        bist_start, inject_fault -> bist_busy, bist_done, bist_pass, err_cnt.
module logic_gate_bist #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic             out_y,
  input  logic             bist_start,
  input  logic             inject_fault,
  output logic             bist_busy,
  output logic             bist_done,
  output logic             bist_pass,
  output logic [WIDTH:0]   err_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [2:0]       op_lat;
  logic [WIDTH-1:0] vec;
  logic             res_q;
  logic             exp_q;

  // Reduction of the selected op over every input bit; reserved codes give 0.
  function automatic logic gate_fn(input logic [2:0] f, input logic [WIDTH-1:0] v);
    logic r;
    case (f)
      3'b000:  r = &v;
      3'b001:  r = |v;
      3'b010:  r = ^v;
      3'b011:  r = ~&v;
      3'b100:  r = ~|v;
      3'b101:  r = ~^v;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic             in_bist;
  logic [2:0]       dp_op;
  logic [WIDTH-1:0] dp_vec;
  logic             dp_y;
  logic             gold_y;
  logic             mismatch;
  logic [WIDTH:0]   err_inc;
  logic [WIDTH-1:0] vec_nxt;

  // The datapath is shared: BIST drives it from the latched op and sweep counter,
  // functional mode from the live inputs. The fault flip applies in both modes.
  assign in_bist  = (state == S_RUN);
  assign dp_op    = in_bist ? op_lat : op;
  assign dp_vec   = in_bist ? vec : in_data;
  assign dp_y     = gate_fn(dp_op, dp_vec) ^ inject_fault;
  assign gold_y   = gate_fn(op_lat, vec);
  assign mismatch = res_q ^ exp_q;
  assign err_inc  = err_cnt + {{WIDTH{1'b0}}, mismatch};
  assign vec_nxt  = vec + {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_lat    <= 3'b000;
      vec       <= '0;
      res_q     <= 1'b0;
      exp_q     <= 1'b0;
      out_valid <= 1'b0;
      out_y     <= 1'b0;
      bist_busy <= 1'b0;
      bist_done <= 1'b0;
      bist_pass <= 1'b0;
      err_cnt   <= '0;
    end else begin
      case (state)
        S_RUN: begin
          out_valid <= 1'b0;
          res_q     <= dp_y;
          exp_q     <= gold_y;
          // The pair registered on the previous RUN edge is only meaningful
          // once the first vector has been captured, i.e. from vec==1 on.
          if (|vec) err_cnt <= err_inc;
          vec <= vec_nxt;
          if (&vec) state <= S_DRAIN;
        end
        S_DRAIN: begin
          out_valid <= 1'b0;
          err_cnt   <= err_inc;
          bist_busy <= 1'b0;
          bist_done <= 1'b1;
          bist_pass <= ~|err_inc;
          state     <= S_DONE;
        end
        default: begin
          // IDLE and DONE: functional mode; bist_start wins over in_valid.
          if (bist_start) begin
            state     <= S_RUN;
            op_lat    <= op;
            vec       <= '0;
            err_cnt   <= '0;
            bist_done <= 1'b0;
            bist_pass <= 1'b0;
            bist_busy <= 1'b1;
            out_valid <= 1'b0;
          end else begin
            out_valid <= in_valid;
            if (in_valid) out_y <= dp_y;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_gate_bist.sv
module tb_logic_gate_bist;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] op;
  logic       in_valid;
  logic [3:0] in_data;
  logic       bist_start;
  logic       inject_fault;
  logic       out_valid, out_y, bist_busy, bist_done, bist_pass;
  logic [4:0] err_cnt;

  logic [2:0] op2;
  logic       in_valid2;
  logic [1:0] in_data2;
  logic       bist_start2;
  logic       inject_fault2;
  logic       out_valid2, out_y2, bist_busy2, bist_done2, bist_pass2;
  logic [2:0] err_cnt2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  logic_gate_bist #(.WIDTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .op(op), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_y(out_y), .bist_start(bist_start),
    .inject_fault(inject_fault), .bist_busy(bist_busy), .bist_done(bist_done),
    .bist_pass(bist_pass), .err_cnt(err_cnt)
  );

  logic_gate_bist #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .op(op2), .in_valid(in_valid2), .in_data(in_data2),
    .out_valid(out_valid2), .out_y(out_y2), .bist_start(bist_start2),
    .inject_fault(inject_fault2), .bist_busy(bist_busy2), .bist_done(bist_done2),
    .bist_pass(bist_pass2), .err_cnt(err_cnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one BIST on the WIDTH=4 instance. edges counts clock edges after the
  // start edge up to the one that raised bist_done. inject_fault is high for
  // edges numbered inj_from .. inj_from+inj_len-1 (edge 0 = start edge).
  task automatic do_bist(input logic [2:0] o, input logic start_with_valid,
                         input int inj_from, input int inj_len, input logic misbehave,
                         output int edges, output int busy_cnt, output int ov_seen);
    op = o;
    bist_start = 1'b1;
    in_valid = start_with_valid;
    in_data = 4'hF;
    inject_fault = (inj_from <= 0) && (0 < inj_from + inj_len);
    step();
    edges = 0; busy_cnt = 0; ov_seen = 0;
    while (!bist_done && edges < 64) begin
      if (bist_busy) busy_cnt++;
      if (out_valid) ov_seen++;
      bist_start = 1'b0;
      in_valid = 1'b0;
      op = o;
      if (misbehave && edges < 16) begin
        bist_start = edges[0];
        in_valid = ~edges[0];
        op = edges[2:0];
        in_data = edges[3:0];
      end
      inject_fault = (edges + 1 >= inj_from) && (edges + 1 < inj_from + inj_len);
      step();
      edges++;
    end
    if (out_valid) ov_seen++;
    bist_start = 1'b0;
    in_valid = 1'b0;
    inject_fault = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_y !== 1'b0) $display("FAIL reset_out_y: got %b want 0", out_y); else passed++;
    total++; if (bist_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bist_busy); else passed++;
    total++; if (bist_done !== 1'b0) $display("FAIL reset_done: got %b want 0", bist_done); else passed++;
    total++; if (bist_pass !== 1'b0) $display("FAIL reset_pass: got %b want 0", bist_pass); else passed++;
    total++; if (err_cnt !== 5'd0) $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_func_and();
    op = 3'b000; in_valid = 1'b1; in_data = 4'b1111;
    step();
    total++; if (out_y !== 1'b1) $display("FAIL and_1111_y: got %b want 1", out_y); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL and_1111_valid: got %b want 1", out_valid); else passed++;
    in_data = 4'b1110;
    step();
    total++; if (out_y !== 1'b0) $display("FAIL and_1110_y: got %b want 0", out_y); else passed++;
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL and_idle_valid: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_op_sweep();
    logic [5:0] exp_bits;
    exp_bits = 6'b101010;  // bit k = result for op k on 0110
    in_valid = 1'b1; in_data = 4'b0110;
    for (int k = 0; k < 6; k++) begin
      op = k[2:0];
      step();
      total++;
      if (out_y !== exp_bits[k]) $display("FAIL op_sweep_%0d: got %b want %b", k, out_y, exp_bits[k]);
      else passed++;
    end
    op = 3'b111;
    step();
    total++; if (out_y !== 1'b0) $display("FAIL op_reserved: got %b want 0", out_y); else passed++;
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_clean_bist();
    int e, b, ov;
    do_bist(3'b010, 1'b0, 0, 0, 1'b0, e, b, ov);
    total++; if (e != 17) $display("FAIL clean_done_edges: got %0d want 17", e); else passed++;
    total++; if (b != 17) $display("FAIL clean_busy_cycles: got %0d want 17", b); else passed++;
    total++; if (bist_pass !== 1'b1) $display("FAIL clean_pass: got %b want 1", bist_pass); else passed++;
    total++; if (err_cnt !== 5'd0) $display("FAIL clean_err_cnt: got %0d want 0", err_cnt); else passed++;
    total++; if (ov != 0) $display("FAIL clean_out_valid_seen: got %0d want 0", ov); else passed++;
  endtask

  task automatic test_fault_inject();
    int e, b, ov;
    do_bist(3'b000, 1'b0, 1, 16, 1'b0, e, b, ov);
    total++; if (err_cnt !== 5'd16) $display("FAIL fault_all_err_cnt: got %0d want 16", err_cnt); else passed++;
    total++; if (bist_pass !== 1'b0) $display("FAIL fault_all_pass: got %b want 0", bist_pass); else passed++;
    // Functional mode is live in DONE while the result stays put.
    op = 3'b000; in_valid = 1'b1; in_data = 4'hF;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_y !== 1'b1)
      $display("FAIL done_functional: got valid=%b y=%b want 1 1", out_valid, out_y); else passed++;
    total++; if (err_cnt !== 5'd16) $display("FAIL done_hold_err_cnt: got %0d want 16", err_cnt); else passed++;
    step();
    do_bist(3'b001, 1'b0, 5, 3, 1'b0, e, b, ov);
    total++; if (err_cnt !== 5'd3) $display("FAIL fault3_err_cnt: got %0d want 3", err_cnt); else passed++;
    total++; if (bist_pass !== 1'b0) $display("FAIL fault3_pass: got %b want 0", bist_pass); else passed++;
  endtask

  task automatic test_ignore_inputs();
    int e, b, ov;
    do_bist(3'b101, 1'b0, 0, 0, 1'b1, e, b, ov);
    total++; if (e != 17) $display("FAIL ignore_done_edges: got %0d want 17", e); else passed++;
    total++; if (ov != 0) $display("FAIL ignore_out_valid_seen: got %0d want 0", ov); else passed++;
    total++; if (bist_pass !== 1'b1 || err_cnt !== 5'd0)
      $display("FAIL ignore_result: got pass=%b err=%0d want 1 0", bist_pass, err_cnt); else passed++;
  endtask

  task automatic test_reset_mid_bist();
    int e, b, ov;
    op = 3'b001; in_valid = 1'b1; in_data = 4'hF;
    step();
    in_valid = 1'b0;
    total++; if (out_y !== 1'b1) $display("FAIL premid_out_y: got %b want 1", out_y); else passed++;
    op = 3'b010; bist_start = 1'b1; inject_fault = 1'b1;
    step();
    bist_start = 1'b0;
    repeat (7) step();
    total++; if (bist_busy !== 1'b1 || err_cnt !== 5'd6)
      $display("FAIL mid_state: got busy=%b err=%0d want 1 6", bist_busy, err_cnt); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if ({out_valid, out_y, bist_busy, bist_done, bist_pass} !== 5'b00000)
      $display("FAIL mid_reset_flags: got %b want 00000", {out_valid, out_y, bist_busy, bist_done, bist_pass}); else passed++;
    total++; if (err_cnt !== 5'd0) $display("FAIL mid_reset_err_cnt: got %0d want 0", err_cnt); else passed++;
    inject_fault = 1'b0;
    rst_n = 1'b1;
    step();
    total++; if (bist_busy !== 1'b0 || bist_done !== 1'b0)
      $display("FAIL mid_reset_idle: got busy=%b done=%b want 0 0", bist_busy, bist_done); else passed++;
    // Start from IDLE with in_valid on the same edge: BIST must win.
    do_bist(3'b011, 1'b1, 0, 0, 1'b0, e, b, ov);
    total++; if (ov != 0) $display("FAIL priority_out_valid_seen: got %0d want 0", ov); else passed++;
    total++; if (e != 17) $display("FAIL after_reset_edges: got %0d want 17", e); else passed++;
    total++; if (bist_pass !== 1'b1 || err_cnt !== 5'd0)
      $display("FAIL after_reset_result: got pass=%b err=%0d want 1 0", bist_pass, err_cnt); else passed++;
  endtask

  task automatic test_width2_bist();
    int n;
    op2 = 3'b010; bist_start2 = 1'b1;
    step();
    bist_start2 = 1'b0;
    n = 0;
    while (!bist_done2 && n < 32) begin
      step();
      n++;
    end
    total++; if (n != 5) $display("FAIL w2_done_edges: got %0d want 5", n); else passed++;
    total++; if (bist_pass2 !== 1'b1) $display("FAIL w2_pass: got %b want 1", bist_pass2); else passed++;
    total++; if (err_cnt2 !== 3'd0) $display("FAIL w2_err_cnt: got %0d want 0", err_cnt2); else passed++;
  endtask

  initial begin
    op = 3'b000; in_valid = 1'b0; in_data = 4'h0; bist_start = 1'b0; inject_fault = 1'b0;
    op2 = 3'b000; in_valid2 = 1'b0; in_data2 = 2'b00; bist_start2 = 1'b0; inject_fault2 = 1'b0;
    test_reset();
    test_func_and();
    test_op_sweep();
    test_clean_bist();
    test_fault_inject();
    test_ignore_inputs();
    test_reset_mid_bist();
    test_width2_bist();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
